// File: rtl/actor_token_fifo_pkg.sv
// Shared constants and helpers for the actor token FIFO slice.
package actor_token_fifo_pkg;

  localparam int unsigned TOKEN_W_DEFAULT = 8;
  localparam int unsigned COUNT_W         = 16;

  // Smallest r with 2**r >= value; evaluated at elaboration time.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/actor_token_fifo_ram.sv
// Token storage: DEPTH x DATA_W, one synchronous write port, asynchronous read.
module actor_token_fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/actor_token_fifo.sv
// First-word fall-through token FIFO between two dataflow actors, with sticky protocol-error flag.
module actor_token_fifo
  import actor_token_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = TOKEN_W_DEFAULT,
  parameter int unsigned DEPTH  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [DATA_W-1:0]  In_DATA,
  input  logic               In_SEND,
  input  logic [COUNT_W-1:0] In_COUNT,
  output logic               In_RDY,
  output logic               In_ACK,
  output logic [DATA_W-1:0]  Out_DATA,
  output logic               Out_SEND,
  output logic [COUNT_W-1:0] Out_COUNT,
  input  logic               Out_ACK,
  output logic               Err
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [OW-1:0]     occupancy;
  logic              err_q;
  logic              wr_en;
  logic              rd_en;
  logic              proto_err;
  logic [DATA_W-1:0] rd_data;

  // Handshake outputs derive from registered occupancy only, so a full FIFO
  // never accepts a token even when the head is popped in the same cycle.
  always_comb begin
    In_RDY    = occupancy < OW'(DEPTH);
    In_ACK    = RESET & In_SEND & In_RDY;
    Out_SEND  = occupancy != '0;
    Out_DATA  = Out_SEND ? rd_data : '0;
    Out_COUNT = COUNT_W'(occupancy);
    wr_en     = In_ACK;
    rd_en     = Out_ACK & Out_SEND;
    proto_err = (Out_ACK & ~Out_SEND) | (In_SEND & (In_COUNT != COUNT_W'(1)));
    Err       = err_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
      err_q     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (proto_err) err_q <= 1'b1;
    end
  end

  actor_token_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (In_DATA),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_actor_token_fifo.sv
// Self-checking bench: queue model checked every cycle plus directed literal checks.
module tb_actor_token_fifo;

  localparam int unsigned DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  In_DATA;
  logic        In_SEND;
  logic [15:0] In_COUNT;
  logic        In_RDY;
  logic        In_ACK;
  logic [7:0]  Out_DATA;
  logic        Out_SEND;
  logic [15:0] Out_COUNT;
  logic        Out_ACK;
  logic        Err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq[$];
  logic       merr = 1'b0;
  logic       started = 1'b0;
  logic [7:0] pop_log[$];

  actor_token_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .In_DATA   (In_DATA),
    .In_SEND   (In_SEND),
    .In_COUNT  (In_COUNT),
    .In_RDY    (In_RDY),
    .In_ACK    (In_ACK),
    .Out_DATA  (Out_DATA),
    .Out_SEND  (Out_SEND),
    .Out_COUNT (Out_COUNT),
    .Out_ACK   (Out_ACK),
    .Err       (Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a token queue updated from the inputs seen at each edge.
  always @(posedge CLK) begin
    logic acc, pop;
    started = 1'b1;
    if (!RESET) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      acc = In_SEND && (mq.size() < DEPTH);
      pop = Out_ACK && (mq.size() != 0);
      if (Out_ACK && mq.size() == 0) merr = 1'b1;
      if (In_SEND && In_COUNT != 16'd1) merr = 1'b1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(In_DATA);
    end
  end

  // Compare process: outputs are stable mid-cycle, checked at every falling edge.
  always @(negedge CLK) begin
    int unsigned sz;
    if (started) begin
      sz = mq.size();
      chk("m_In_RDY",    32'(In_RDY),    32'(sz < DEPTH));
      chk("m_In_ACK",    32'(In_ACK),    32'(RESET && In_SEND && sz < DEPTH));
      chk("m_Out_SEND",  32'(Out_SEND),  32'(sz != 0));
      chk("m_Out_COUNT", 32'(Out_COUNT), sz);
      chk("m_Out_DATA",  32'(Out_DATA),  (sz != 0) ? 32'(mq[0]) : 32'd0);
      chk("m_Err",       32'(Err),       32'(merr));
      if (RESET && Out_ACK && Out_SEND) pop_log.push_back(Out_DATA);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    RESET = 1'b0; In_DATA = '0; In_SEND = 1'b0; In_COUNT = 16'd1; Out_ACK = 1'b0;
    step();
    step();
    chk("rst_count", 32'(Out_COUNT), 0);
    chk("rst_rdy",   32'(In_RDY),    1);
    chk("rst_send",  32'(Out_SEND),  0);
    chk("rst_data",  32'(Out_DATA),  0);
    RESET = 1'b1;

    // Three writes, no pops
    for (int i = 0; i < 3; i++) begin
      In_SEND = 1'b1; In_DATA = vals[i];
      #1 chk("w3_ack", 32'(In_ACK), 1);
      step();
      chk("w3_count", 32'(Out_COUNT), 32'(i + 1));
      chk("w3_head",  32'(Out_DATA),  32'h11);
    end
    In_SEND = 1'b0;
    do_reset();

    // Fill past capacity
    for (int i = 0; i < 17; i++) begin
      In_SEND = 1'b1; In_DATA = 8'(i);
      #1 chk("fill_ack", 32'(In_ACK), 32'(i < 16));
      step();
    end
    chk("full_count", 32'(Out_COUNT), 16);
    chk("full_rdy",   32'(In_RDY),    0);

    // Full with simultaneous offer and pop: pop only
    In_SEND = 1'b1; In_DATA = 8'hAA; Out_ACK = 1'b1;
    #1 chk("fullpop_ack", 32'(In_ACK), 0);
    step();
    chk("fullpop_count", 32'(Out_COUNT), 15);
    chk("fullpop_head",  32'(Out_DATA),  1);
    Out_ACK = 1'b0;
    #1 chk("refill_ack", 32'(In_ACK), 1);
    step();
    chk("refill_count", 32'(Out_COUNT), 16);
    In_SEND = 1'b0;
    do_reset();

    // Streaming 40 tokens, occupancy held at 1
    pop_log.delete();
    In_SEND = 1'b1; In_DATA = 8'h00;
    step();
    for (int i = 1; i < 40; i++) begin
      In_DATA = 8'(i); Out_ACK = 1'b1;
      step();
      chk("stream_count", 32'(Out_COUNT), 1);
      chk("stream_head",  32'(Out_DATA),  32'(i));
    end
    In_SEND = 1'b0;
    step();
    Out_ACK = 1'b0;
    chk("stream_end_count", 32'(Out_COUNT), 0);
    chk("stream_log_size",  32'(pop_log.size()), 40);
    for (int k = 0; k < pop_log.size() && k < 40; k++)
      chk("stream_order", 32'(pop_log[k]), 32'(k));

    // Illegal pop while empty, then illegal count
    Out_ACK = 1'b1;
    step();
    Out_ACK = 1'b0;
    chk("emptyack_err",   32'(Err),       1);
    chk("emptyack_count", 32'(Out_COUNT), 0);
    step();
    step();
    chk("err_sticky", 32'(Err), 1);
    do_reset();
    chk("err_cleared", 32'(Err), 0);
    In_SEND = 1'b1; In_COUNT = 16'd2; In_DATA = 8'h5C;
    #1 chk("badcnt_ack", 32'(In_ACK), 1);
    step();
    In_SEND = 1'b0; In_COUNT = 16'd1;
    chk("badcnt_err",   32'(Err),       1);
    chk("badcnt_count", 32'(Out_COUNT), 1);
    chk("badcnt_head",  32'(Out_DATA),  32'h5C);

    // Empty: write plus Out_ACK does not bypass
    do_reset();
    In_SEND = 1'b1; In_DATA = 8'h77; Out_ACK = 1'b1;
    step();
    In_SEND = 1'b0; Out_ACK = 1'b0;
    chk("nobypass_count", 32'(Out_COUNT), 1);
    chk("nobypass_err",   32'(Err),       1);

    // Reset mid-operation with 5 tokens stored
    for (int i = 0; i < 4; i++) begin
      In_SEND = 1'b1; In_DATA = 8'(8'h40 + i);
      step();
    end
    In_SEND = 1'b0;
    chk("pre_rst_count", 32'(Out_COUNT), 5);
    RESET = 1'b0; In_SEND = 1'b1;
    #1 chk("rst_ack_low", 32'(In_ACK), 0);
    step();
    RESET = 1'b1; In_SEND = 1'b0;
    chk("midrst_count", 32'(Out_COUNT), 0);
    chk("midrst_send",  32'(Out_SEND),  0);
    chk("midrst_err",   32'(Err),       0);
    chk("midrst_rdy",   32'(In_RDY),    1);
    chk("midrst_data",  32'(Out_DATA),  0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
